// File: rtl/raw_pattern_gen.sv
// Raw Bayer-domain test pattern generator: emits frames of ACTIVE pixels with
// horizontal and vertical blanking, selectable ramp / RGGB flat / checker / constant.
module raw_pattern_gen #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned V_ACTIVE = 960,
    parameter int unsigned V_BLANK  = 4
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iEN,
    input  logic [1:0]  iMODE,
    input  logic [11:0] iLEVEL,
    output logic [11:0] oDATA,
    output logic        oDVAL,
    output logic [10:0] oX_Cont,
    output logic [10:0] oY_Cont,
    output logic        oFVAL,
    output logic        oFrame_Done,
    output logic [15:0] oFrame_Cnt
);

    localparam int unsigned VB_CYCLES = V_BLANK * (H_ACTIVE + H_BLANK);
    localparam int unsigned BW        = $clog2(VB_CYCLES);
    localparam logic [10:0] X_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST    = 11'(V_ACTIVE - 1);
    localparam logic [BW-1:0] HB_LAST = BW'(H_BLANK - 1);
    localparam logic [BW-1:0] VB_PRE  = BW'(VB_CYCLES - 2);
    localparam logic [BW-1:0] VB_LAST = BW'(VB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        HBLANK,
        VBLANK
    } state_t;

    state_t        state;
    logic [1:0]    modeQ;
    logic [11:0]   levelQ;
    logic [BW-1:0] blankCnt;
    logic [10:0]   xNext;
    logic [10:0]   yNext;
    logic [11:0]   startPix;

    // Pixel value for a given pattern at column x on a row with the given parity bits.
    function automatic logic [11:0] pixel(input logic [1:0] m, input logic [11:0] lv,
                                          input logic [10:0] x, input logic yOdd,
                                          input logic yB3);
        case (m)
            2'd0:    return {1'b0, x};
            2'd1:    return yOdd ? (x[0] ? 12'h800 : 12'h000)
                                 : (x[0] ? 12'hFFF : 12'h800);
            2'd2:    return (x[3] ^ yB3) ? 12'hFFF : 12'h000;
            default: return lv;
        endcase
    endfunction

    assign xNext    = oX_Cont + 11'd1;
    assign yNext    = oY_Cont + 11'd1;
    // First pixel of a new frame uses the mode/level being latched on the same edge.
    assign startPix = pixel(iMODE, iLEVEL, 11'd0, 1'b0, 1'b0);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state       <= IDLE;
            modeQ       <= '0;
            levelQ      <= '0;
            blankCnt    <= '0;
            oDATA       <= '0;
            oDVAL       <= 1'b0;
            oX_Cont     <= '0;
            oY_Cont     <= '0;
            oFVAL       <= 1'b0;
            oFrame_Done <= 1'b0;
            oFrame_Cnt  <= '0;
        end else begin
            oFrame_Done <= 1'b0;
            oFrame_Cnt  <= oFrame_Cnt;
            case (state)
                IDLE: begin
                    if (iEN) begin
                        state   <= ACTIVE;
                        modeQ   <= iMODE;
                        levelQ  <= iLEVEL;
                        oDATA   <= startPix;
                        oDVAL   <= 1'b1;
                        oFVAL   <= 1'b1;
                        oX_Cont <= '0;
                        oY_Cont <= '0;
                    end
                end
                ACTIVE: begin
                    if (oX_Cont == X_LAST) begin
                        state    <= HBLANK;
                        blankCnt <= '0;
                        oDVAL    <= 1'b0;
                        oDATA    <= '0;
                        oX_Cont  <= '0;
                        // FVAL ends with the last pixel, so the trailing HBLANK is outside it
                        oFVAL    <= (oY_Cont != Y_LAST);
                    end else begin
                        oX_Cont <= xNext;
                        oDATA   <= pixel(modeQ, levelQ, xNext, oY_Cont[0], oY_Cont[3]);
                    end
                end
                HBLANK: begin
                    if (blankCnt == HB_LAST) begin
                        blankCnt <= '0;
                        if (oY_Cont != Y_LAST) begin
                            state   <= ACTIVE;
                            oY_Cont <= yNext;
                            oDVAL   <= 1'b1;
                            oFVAL   <= 1'b1;
                            oDATA   <= pixel(modeQ, levelQ, 11'd0, yNext[0], yNext[3]);
                        end else begin
                            state   <= VBLANK;
                            oY_Cont <= '0;
                            oFVAL   <= 1'b0;
                        end
                    end else begin
                        blankCnt <= blankCnt + BW'(1);
                    end
                end
                VBLANK: begin
                    blankCnt <= blankCnt + BW'(1);
                    if (blankCnt == VB_PRE) begin
                        oFrame_Done <= 1'b1;
                        oFrame_Cnt  <= oFrame_Cnt + 16'd1;
                    end
                    if (blankCnt == VB_LAST) begin
                        blankCnt <= '0;
                        if (iEN) begin
                            state   <= ACTIVE;
                            modeQ   <= iMODE;
                            levelQ  <= iLEVEL;
                            oDATA   <= startPix;
                            oDVAL   <= 1'b1;
                            oFVAL   <= 1'b1;
                            oX_Cont <= '0;
                            oY_Cont <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_raw_pattern_gen.sv
// Bench for raw_pattern_gen: per-cycle comparison against a frame-position model.
module tb_raw_pattern_gen;

    localparam int HA = 8, HB = 2, VA = 4, VB = 1;
    localparam int PERIOD = (VA + VB) * (HA + HB);
    localparam int HA2 = 24, HB2 = 3, VA2 = 18, VB2 = 2;
    localparam int PERIOD2 = (VA2 + VB2) * (HA2 + HB2);

    logic        iCLK, iRST;
    logic        iEN, iEN2;
    logic [1:0]  iMODE, iMODE2;
    logic [11:0] iLEVEL, iLEVEL2;
    logic [11:0] oDATA, oDATA2;
    logic        oDVAL, oDVAL2, oFVAL, oFVAL2, oFrame_Done, oFrame_Done2;
    logic [10:0] oX_Cont, oY_Cont, oX_Cont2, oY_Cont2;
    logic [15:0] oFrame_Cnt, oFrame_Cnt2;
    logic [36:0] obs, obs2;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [15:0] expCnt;

    raw_pattern_gen #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)) dut (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iMODE(iMODE), .iLEVEL(iLEVEL),
        .oDATA(oDATA), .oDVAL(oDVAL), .oX_Cont(oX_Cont), .oY_Cont(oY_Cont),
        .oFVAL(oFVAL), .oFrame_Done(oFrame_Done), .oFrame_Cnt(oFrame_Cnt)
    );

    raw_pattern_gen #(.H_ACTIVE(HA2), .H_BLANK(HB2), .V_ACTIVE(VA2), .V_BLANK(VB2)) dut2 (
        .iCLK(iCLK), .iRST(iRST), .iEN(iEN2), .iMODE(iMODE2), .iLEVEL(iLEVEL2),
        .oDATA(oDATA2), .oDVAL(oDVAL2), .oX_Cont(oX_Cont2), .oY_Cont(oY_Cont2),
        .oFVAL(oFVAL2), .oFrame_Done(oFrame_Done2), .oFrame_Cnt(oFrame_Cnt2)
    );

    assign obs  = {oDATA, oDVAL, oX_Cont, oY_Cont, oFVAL, oFrame_Done};
    assign obs2 = {oDATA2, oDVAL2, oX_Cont2, oY_Cont2, oFVAL2, oFrame_Done2};

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Expected {data,dval,x,y,fval,done} at cycle t of a frame (t=0 is the first pixel).
    function automatic logic [36:0] model(input int t, input int hA, input int hB,
                                          input int vA, input int vB,
                                          input logic [1:0] m, input logic [11:0] lv);
        int          lineLen;
        int          row;
        int          col;
        logic [11:0] d;
        logic        dv, fv, dn;
        logic [10:0] x, y;
        lineLen = hA + hB;
        row = t / lineLen;
        col = t % lineLen;
        d = '0; dv = 1'b0; fv = 1'b0; dn = 1'b0; x = '0; y = '0;
        if (row < vA) begin
            y  = 11'(row);
            fv = (col < hA) || (row < vA - 1);
            if (col < hA) begin
                dv = 1'b1;
                x  = 11'(col);
                case (m)
                    2'd0: d = 12'(col);
                    2'd1: begin
                        if (row % 2 == 0) d = (col % 2 == 0) ? 12'h800 : 12'hFFF;
                        else              d = (col % 2 == 0) ? 12'h000 : 12'h800;
                    end
                    2'd2: d = (((col / 8) % 2) != ((row / 8) % 2)) ? 12'hFFF : 12'h000;
                    default: d = lv;
                endcase
            end
        end else begin
            dn = (t == lineLen * (vA + vB) - 1);
        end
        return {d, dv, x, y, fv, dn};
    endfunction

    task automatic test_reset();
        iRST = 1'b0; iEN = 1'b0; iEN2 = 1'b0;
        iMODE = 2'd0; iLEVEL = 12'd0; iMODE2 = 2'd2; iLEVEL2 = 12'd0;
        repeat (2) @(negedge iCLK);
        nChecks++;
        if (obs !== 37'd0) begin
            nFails++; $display("FAIL reset_outputs got %h want 0", obs);
        end
        nChecks++;
        if (oFrame_Cnt !== 16'd0) begin
            nFails++; $display("FAIL reset_cnt got %h want 0", oFrame_Cnt);
        end
        iRST = 1'b1;
        expCnt = 16'd0;
        for (int i = 0; i < 4; i++) begin
            @(negedge iCLK);
            nChecks++;
            if (obs !== 37'd0) begin
                nFails++; $display("FAIL idle_no_en got %h want 0", obs);
            end
        end
    endtask

    task automatic test_ramp();
        logic [36:0] exp;
        logic [11:0] fl;
        int nDval, nDone;
        nDval = 0; nDone = 0;
        fl = 12'($urandom);
        iEN = 1'b1; iMODE = 2'd0; iLEVEL = fl;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, 2'd0, fl);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL ramp t=%0d got %h want %h", t, obs, exp);
            end
            if (t == 7) begin
                nChecks++;
                if (oDATA !== 12'd7 || oX_Cont !== 11'd7) begin
                    nFails++; $display("FAIL ramp_x7 got data %h x %0d want 007 x 7", oDATA, oX_Cont);
                end
            end
            nDval += int'(oDVAL);
            nDone += int'(oFrame_Done);
            if (t == PERIOD - 1) begin
                expCnt++;
                iEN = 1'b0;
            end
        end
        nChecks++;
        if (nDval != 32) begin
            nFails++; $display("FAIL ramp_dval_count got %0d want 32", nDval);
        end
        nChecks++;
        if (nDone != 1) begin
            nFails++; $display("FAIL ramp_done_count got %0d want 1", nDone);
        end
        nChecks++;
        if (oFrame_Cnt !== expCnt) begin
            nFails++; $display("FAIL ramp_cnt got %h want %h", oFrame_Cnt, expCnt);
        end
        @(negedge iCLK);
        nChecks++;
        if (obs !== 37'd0) begin
            nFails++; $display("FAIL ramp_idle got %h want 0", obs);
        end
    endtask

    task automatic test_bayer();
        logic [36:0] exp;
        logic [11:0] want;
        iEN = 1'b1; iMODE = 2'd1; iLEVEL = 12'd0;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, 2'd1, 12'd0);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL bayer t=%0d got %h want %h", t, obs, exp);
            end
            if (t == 0 || t == 1 || t == 10 || t == 11) begin
                case (t)
                    0:       want = 12'h800;
                    1:       want = 12'hFFF;
                    10:      want = 12'h000;
                    default: want = 12'h800;
                endcase
                nChecks++;
                if (oDATA !== want) begin
                    nFails++; $display("FAIL bayer_const t=%0d got %h want %h", t, oDATA, want);
                end
            end
            if (t == PERIOD - 1) begin
                expCnt++;
                iEN = 1'b0;
            end
        end
        @(negedge iCLK);
    endtask

    task automatic test_back_to_back();
        logic [36:0] exp;
        logic [1:0]  fm;
        logic [11:0] fl;
        iEN = 1'b1; iMODE = 2'd0; iLEVEL = 12'h5A5;
        fm = iMODE; fl = iLEVEL;
        for (int f = 0; f < 3; f++) begin
            for (int t = 0; t < PERIOD; t++) begin
                @(negedge iCLK);
                exp = model(t, HA, HB, VA, VB, fm, fl);
                nChecks++;
                if (obs !== exp) begin
                    nFails++; $display("FAIL b2b f=%0d t=%0d got %h want %h", f, t, obs, exp);
                end
                if (f == 0 && t == 20) begin
                    iMODE = 2'd3; iLEVEL = 12'h123;
                end
                if (t == PERIOD - 1) begin
                    expCnt++;
                    nChecks++;
                    if (oFrame_Cnt !== expCnt) begin
                        nFails++; $display("FAIL b2b_cnt f=%0d got %h want %h", f, oFrame_Cnt, expCnt);
                    end
                    if (f == 2) iEN = 1'b0;
                    fm = iMODE; fl = iLEVEL;
                end
            end
        end
        @(negedge iCLK);
    endtask

    task automatic test_random();
        logic [36:0] exp;
        logic [1:0]  fm;
        logic [11:0] fl;
        iEN = 1'b1; iMODE = 2'($urandom_range(0, 3)); iLEVEL = 12'($urandom);
        fm = iMODE; fl = iLEVEL;
        for (int f = 0; f < 5; f++) begin
            for (int t = 0; t < PERIOD; t++) begin
                @(negedge iCLK);
                exp = model(t, HA, HB, VA, VB, fm, fl);
                nChecks++;
                if (obs !== exp) begin
                    nFails++; $display("FAIL rand f=%0d m=%0d t=%0d got %h want %h", f, fm, t, obs, exp);
                end
                if (t == PERIOD - 1) begin
                    expCnt++;
                    nChecks++;
                    if (oFrame_Cnt !== expCnt) begin
                        nFails++; $display("FAIL rand_cnt f=%0d got %h want %h", f, oFrame_Cnt, expCnt);
                    end
                    iEN = (f != 4);
                    fm = iMODE; fl = iLEVEL;
                end else begin
                    if ($urandom_range(0, 7) == 0) begin
                        iMODE = 2'($urandom_range(0, 3)); iLEVEL = 12'($urandom);
                    end
                    iEN = 1'($urandom_range(0, 1));
                end
            end
        end
        @(negedge iCLK);
    endtask

    task automatic test_enable_drop();
        logic [36:0] exp;
        logic [11:0] fl;
        int nDone;
        nDone = 0;
        fl = 12'($urandom);
        iEN = 1'b1; iMODE = 2'd3; iLEVEL = fl;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, 2'd3, fl);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL en_drop t=%0d got %h want %h", t, obs, exp);
            end
            nDone += int'(oFrame_Done);
            if (t == 10) iEN = 1'b0;
            if (t == PERIOD - 1) expCnt++;
        end
        nChecks++;
        if (nDone != 1) begin
            nFails++; $display("FAIL en_drop_done got %0d want 1", nDone);
        end
        nChecks++;
        if (oFrame_Cnt !== expCnt) begin
            nFails++; $display("FAIL en_drop_cnt got %h want %h", oFrame_Cnt, expCnt);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge iCLK);
            nChecks++;
            if (obs !== 37'd0) begin
                nFails++; $display("FAIL en_drop_idle i=%0d got %h want 0", i, obs);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [36:0] exp;
        iEN = 1'b1; iMODE = 2'd0; iLEVEL = 12'd0;
        for (int t = 0; t <= 20; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, 2'd0, 12'd0);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL prereset t=%0d got %h want %h", t, obs, exp);
            end
        end
        #2 iRST = 1'b0;
        #1;
        expCnt = 16'd0;
        nChecks++;
        if (obs !== 37'd0) begin
            nFails++; $display("FAIL async_reset got %h want 0", obs);
        end
        nChecks++;
        if (oFrame_Cnt !== 16'd0) begin
            nFails++; $display("FAIL async_reset_cnt got %h want 0", oFrame_Cnt);
        end
        iEN = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            nChecks++;
            if (obs !== 37'd0) begin
                nFails++; $display("FAIL post_reset_idle got %h want 0", obs);
            end
        end
        iEN = 1'b1;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, 2'd0, 12'd0);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL restart t=%0d got %h want %h", t, obs, exp);
            end
            if (t == PERIOD - 1) begin
                expCnt++;
                iEN = 1'b0;
            end
        end
        nChecks++;
        if (oFrame_Cnt !== expCnt) begin
            nFails++; $display("FAIL restart_cnt got %h want %h", oFrame_Cnt, expCnt);
        end
        @(negedge iCLK);
    endtask

    task automatic test_wrap();
        logic [36:0] exp;
        logic [1:0]  fm;
        logic [11:0] fl;
        force dut.oFrame_Cnt = 16'hFFFF;
        @(negedge iCLK);
        release dut.oFrame_Cnt;
        #1;
        expCnt = 16'hFFFF;
        nChecks++;
        if (oFrame_Cnt !== expCnt) begin
            nFails++; $display("FAIL wrap_preload got %h want %h", oFrame_Cnt, expCnt);
        end
        fm = 2'($urandom_range(0, 3)); fl = 12'($urandom);
        iEN = 1'b1; iMODE = fm; iLEVEL = fl;
        for (int t = 0; t < PERIOD; t++) begin
            @(negedge iCLK);
            exp = model(t, HA, HB, VA, VB, fm, fl);
            nChecks++;
            if (obs !== exp) begin
                nFails++; $display("FAIL wrap_frame t=%0d got %h want %h", t, obs, exp);
            end
            if (t == PERIOD - 1) begin
                expCnt++;
                iEN = 1'b0;
            end
        end
        nChecks++;
        if (oFrame_Cnt !== 16'h0000 || oFrame_Cnt !== expCnt) begin
            nFails++; $display("FAIL wrap_cnt got %h want 0000", oFrame_Cnt);
        end
        @(negedge iCLK);
    endtask

    task automatic test_checker_large();
        logic [36:0] exp;
        iEN2 = 1'b1; iMODE2 = 2'd2; iLEVEL2 = 12'd0;
        for (int t = 0; t < PERIOD2; t++) begin
            @(negedge iCLK);
            exp = model(t, HA2, HB2, VA2, VB2, 2'd2, 12'd0);
            nChecks++;
            if (obs2 !== exp) begin
                nFails++; $display("FAIL checker t=%0d got %h want %h", t, obs2, exp);
            end
            if (t == PERIOD2 - 1) iEN2 = 1'b0;
        end
        nChecks++;
        if (oFrame_Cnt2 !== 16'd1) begin
            nFails++; $display("FAIL checker_cnt got %h want 0001", oFrame_Cnt2);
        end
        @(negedge iCLK);
        nChecks++;
        if (obs2 !== 37'd0) begin
            nFails++; $display("FAIL checker_idle got %h want 0", obs2);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_bayer();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_reset_mid_frame();
        test_wrap();
        test_checker_large();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
